// File: rtl/sseg_serial_driver.sv
`timescale 1ns/1ps
// Serial driver for a shift-register seven-segment display: captures a frame,
// encodes each digit (hex text or raw graphic), and shifts it out with a latch strobe.
module sseg_serial_driver #(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  auto_refresh,
    input  logic                  mode,
    input  logic [8*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     le,
    input  logic [DIGITS-1:0]     blink,
    output logic                  seg_clk,
    output logic                  seg_dout,
    output logic                  seg_latch,
    output logic                  busy,
    output logic                  done
);

    localparam int FRAME_BITS = 8 * DIGITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRM_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(CLK_DIV - 1);
    localparam logic [FRM_W-1:0] LAST_FRM  = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_LO = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]            r_state;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRM_W-1:0]      r_frame_cnt;
    logic                  r_blink_phase;
    logic                  r_seg_clk;
    logic                  r_seg_dout;
    logic                  r_seg_latch;
    logic                  r_busy;
    logic                  r_done;

    logic [2:0]            w_state_nxt;
    logic [DIV_W-1:0]      w_div_nxt;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic [FRAME_BITS-1:0] w_shift_nxt;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_shifting_nxt;

    // Active-low {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_segments(input logic [3:0] nib);
        case (nib)
            4'h0: hex_segments = 7'h40;
            4'h1: hex_segments = 7'h79;
            4'h2: hex_segments = 7'h24;
            4'h3: hex_segments = 7'h30;
            4'h4: hex_segments = 7'h19;
            4'h5: hex_segments = 7'h12;
            4'h6: hex_segments = 7'h02;
            4'h7: hex_segments = 7'h78;
            4'h8: hex_segments = 7'h00;
            4'h9: hex_segments = 7'h10;
            4'hA: hex_segments = 7'h08;
            4'hB: hex_segments = 7'h03;
            4'hC: hex_segments = 7'h46;
            4'hD: hex_segments = 7'h21;
            4'hE: hex_segments = 7'h06;
            default: hex_segments = 7'h0E;
        endcase
    endfunction

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_frame = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!le[i] || (blink[i] && r_blink_phase))
                w_frame[8*i +: 8] = 8'hFF;
            else if (mode)
                w_frame[8*i +: 8] = disp_data[8*i +: 8];
            else
                w_frame[8*i +: 8] = {~point[i], hex_segments(disp_data[4*i +: 4])};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (start || auto_refresh) begin
                    w_state_nxt = S_SHIFT_LO;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = w_frame;
                end
            end
            S_SHIFT_LO: begin
                if (r_div_cnt == LAST_DIV) begin
                    w_state_nxt = S_SHIFT_HI;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (r_div_cnt == LAST_DIV) begin
                    w_div_nxt = '0;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_state_nxt = S_SHIFT_LO;
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_div_cnt == LAST_DIV) begin
                    w_state_nxt = S_DONE;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shifting_nxt = (w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI);

    // Pin outputs are registered from the next state so the board sees glitch-free levels.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_seg_clk   <= 1'b0;
            r_seg_dout  <= 1'b0;
            r_seg_latch <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_seg_clk   <= (w_state_nxt == S_SHIFT_HI);
            r_seg_dout  <= w_shifting_nxt & w_shift_nxt[FRAME_BITS-1];
            r_seg_latch <= (w_state_nxt == S_LATCH);
            r_busy      <= w_shifting_nxt || (w_state_nxt == S_LATCH);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_state == S_DONE) begin
            if (r_frame_cnt == LAST_FRM) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign seg_clk   = r_seg_clk;
    assign seg_dout  = r_seg_dout;
    assign seg_latch = r_seg_latch;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sseg_serial_driver.sv
`timescale 1ns/1ps
// Randomised bench for sseg_serial_driver: two configurations checked against a
// byte-level display model (hex table, blanking, blink phase from frame count).
module tb_sseg_serial_driver;

    localparam int D0 = 8, C0 = 2, B0 = 2;
    localparam int D1 = 4, C1 = 1, B1 = 3;
    localparam int LAT0 = 1 + 16*D0*C0 + C0;
    localparam int LAT1 = 1 + 16*D1*C1 + C1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s0_start, s0_auto, s0_mode;
    logic [63:0] s0_data;
    logic [7:0]  s0_point, s0_le, s0_blink;
    logic        s0_sck, s0_dout, s0_latch, s0_busy, s0_done;

    logic        s1_start, s1_auto, s1_mode;
    logic [31:0] s1_data;
    logic [3:0]  s1_point, s1_le, s1_blink;
    logic        s1_sck, s1_dout, s1_latch, s1_busy, s1_done;

    int     n_vec = 0;
    int     n_err = 0;
    int     frames0 = 0;
    int     frames1 = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    sseg_serial_driver #(.DIGITS(D0), .CLK_DIV(C0), .BLINK_FRAMES(B0)) u_dut0 (
        .clk(clk), .rst(rst), .start(s0_start), .auto_refresh(s0_auto), .mode(s0_mode),
        .disp_data(s0_data), .point(s0_point), .le(s0_le), .blink(s0_blink),
        .seg_clk(s0_sck), .seg_dout(s0_dout), .seg_latch(s0_latch), .busy(s0_busy), .done(s0_done)
    );

    sseg_serial_driver #(.DIGITS(D1), .CLK_DIV(C1), .BLINK_FRAMES(B1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .auto_refresh(s1_auto), .mode(s1_mode),
        .disp_data(s1_data), .point(s1_point), .le(s1_le), .blink(s1_blink),
        .seg_clk(s1_sck), .seg_dout(s1_dout), .seg_latch(s1_latch), .busy(s1_busy), .done(s1_done)
    );

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Whole frame as transmitted, first bit at the MSB end of the used width.
    function automatic logic [63:0] model_frame(input int digits, input logic mode,
                                                input logic [63:0] data, input logic [7:0] point,
                                                input logic [7:0] le, input logic [7:0] blink,
                                                input bit phase);
        logic [63:0] v;
        logic [7:0]  b;
        v = '0;
        for (int d = digits - 1; d >= 0; d--) begin
            if (!le[d] || (blink[d] && phase)) b = 8'hFF;
            else if (mode) b = data[8*d +: 8];
            else begin
                b = hex_tbl[data[4*d +: 4]];
                if (point[d]) b[7] = 1'b0;
            end
            v = {v[55:0], b};
        end
        return v;
    endfunction

    function automatic bit phase0();
        return ((frames0 / B0) % 2) == 1;
    endfunction

    function automatic bit phase1();
        return ((frames1 / B1) % 2) == 1;
    endfunction

    function automatic logic [63:0] exp0();
        return model_frame(D0, s0_mode, s0_data, s0_point, s0_le, s0_blink, phase0());
    endfunction

    function automatic logic [63:0] exp1();
        return model_frame(D1, s1_mode, {32'h0, s1_data}, {4'h0, s1_point}, {4'h0, s1_le},
                           {4'h0, s1_blink}, phase1());
    endfunction

    // Observe one frame from accept to done; optional start pokes at given cycles of the frame.
    task automatic run_frame(input int which, input bit do_start, input int poke_a, input int poke_b,
                             output logic [63:0] cap, output int sck_edges, output int latch_cyc,
                             output int latency, output longint t_acc,
                             output int min_gap, output int max_gap);
        int     n;
        int     bits;
        bit     prev, sck, dout, latch, bsy, dn;
        longint last_rise;
        cap = '0; sck_edges = 0; latch_cyc = 0; latency = 0; t_acc = 0;
        min_gap = 1 << 30; max_gap = 0; prev = 0; last_rise = -1;
        bits = (which == 0) ? 8*D0 : 8*D1;
        if (do_start) begin
            if (which == 0) s0_start = 1'b1; else s1_start = 1'b1;
        end
        n = 0; bsy = 0;
        while (!bsy && n < 100) begin
            @(negedge clk);
            n++;
            bsy = (which == 0) ? s0_busy : s1_busy;
        end
        s0_start = 1'b0; s1_start = 1'b0;
        if (!bsy) begin
            n_vec++; n_err++;
            $display("FAIL frame_accept: busy=0 after 100 cycles, required 1");
            return;
        end
        t_acc = cyc;
        latency = 1;
        dn = 0;
        while (!dn && latency < 5000) begin
            sck   = (which == 0) ? s0_sck   : s1_sck;
            dout  = (which == 0) ? s0_dout  : s1_dout;
            latch = (which == 0) ? s0_latch : s1_latch;
            dn    = (which == 0) ? s0_done  : s1_done;
            if (sck && !prev) begin
                cap = {cap[62:0], dout};
                sck_edges++;
                if (last_rise >= 0) begin
                    if (int'(cyc - last_rise) < min_gap) min_gap = int'(cyc - last_rise);
                    if (int'(cyc - last_rise) > max_gap) max_gap = int'(cyc - last_rise);
                end
                last_rise = cyc;
            end
            prev = sck;
            if (latch) begin
                latch_cyc++;
                n_vec++;
                if (sck_edges !== bits) begin
                    n_err++;
                    $display("FAIL latch_early: latch after %0d bits, required %0d", sck_edges, bits);
                end
            end
            if (!dn) begin
                if (latency == poke_a || latency == poke_b) begin
                    if (which == 0) begin
                        s0_start = 1'b1; s0_data = {$urandom, $urandom};
                        s0_le = 8'($urandom); s0_mode = ~s0_mode;
                    end else begin
                        s1_start = 1'b1; s1_data = $urandom; s1_mode = ~s1_mode;
                    end
                end else begin
                    s0_start = 1'b0; s1_start = 1'b0;
                end
                @(negedge clk);
                latency++;
            end
        end
        if (!dn) begin
            n_vec++; n_err++;
            $display("FAIL frame_done: no done within %0d cycles", latency);
        end else if (which == 0) frames0++;
        else frames1++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        frames0 = 0; frames1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int  n;
        bit  seen;
        s0_start = 0; s0_auto = 0; s0_mode = 0; s0_data = '0; s0_point = '0; s0_le = '1; s0_blink = '0;
        s1_start = 0; s1_auto = 0; s1_mode = 0; s1_data = '0; s1_point = '0; s1_le = '1; s1_blink = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({s0_sck, s0_dout, s0_latch, s0_busy, s0_done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_dut0: outputs=%b required 00000", {s0_sck, s0_dout, s0_latch, s0_busy, s0_done});
        end
        n_vec++;
        if ({s1_sck, s1_dout, s1_latch, s1_busy, s1_done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_dut1: outputs=%b required 00000", {s1_sck, s1_dout, s1_latch, s1_busy, s1_done});
        end
        rst = 1'b0;
        frames0 = 0; frames1 = 0;
        @(negedge clk);
        s0_data = {$urandom, $urandom};
        s0_start = 1'b1;
        n = 0;
        while (!(s0_busy && s0_sck) && n < 100) begin
            @(negedge clk);
            n++;
            if (s0_busy) s0_start = 1'b0;
        end
        s0_start = 1'b0;
        n_vec++;
        if (!(s0_busy && s0_sck)) begin
            n_err++;
            $display("FAIL reset_reach_shift_hi: busy=%b seg_clk=%b, required 1 1", s0_busy, s0_sck);
        end
        repeat (20) @(negedge clk);
        while (!s0_sck && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({s0_sck, s0_dout, s0_latch, s0_busy, s0_done} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_midframe: outputs=%b required 00000", {s0_sck, s0_dout, s0_latch, s0_busy, s0_done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frames0 = 0; frames1 = 0;
        seen = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (s0_latch || s0_busy || s0_done) seen = 1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_latch_after: activity seen=%b required 0", seen);
        end
    endtask

    task automatic test_text();
        logic [63:0] cap, exp;
        int e, l, lat, mn, mx;
        longint t;
        s0_mode = 0; s0_data = {$urandom, 32'h0123_4567};
        s0_point = '0; s0_le = 8'hFF; s0_blink = '0;
        exp = exp0();
        run_frame(0, 1, 0, 0, cap, e, l, lat, t, mn, mx);
        n_vec++;
        if (cap[63:48] !== 16'hC0F9) begin
            n_err++; $display("FAIL text_first16: got %h required C0F9", cap[63:48]);
        end
        n_vec++;
        if (cap !== exp) begin
            n_err++; $display("FAIL text_frame: got %h required %h", cap, exp);
        end
        n_vec++;
        if (e !== 8*D0) begin
            n_err++; $display("FAIL text_edges: got %0d required %0d", e, 8*D0);
        end
        n_vec++;
        if (l !== C0) begin
            n_err++; $display("FAIL text_latch_len: got %0d required %0d", l, C0);
        end
        n_vec++;
        if (lat !== LAT0) begin
            n_err++; $display("FAIL text_latency: got %0d required %0d", lat, LAT0);
        end
    endtask

    task automatic test_graphic();
        logic [63:0] cap, exp;
        int e, l, lat, mn, mx;
        longint t;
        s0_mode = 1; s0_data = {8'h5A, 24'($urandom), $urandom};
        s0_point = 8'($urandom); s0_le = (8'($urandom) | 8'h80) & 8'hBF; s0_blink = '0;
        exp = exp0();
        run_frame(0, 1, 0, 0, cap, e, l, lat, t, mn, mx);
        n_vec++;
        if (cap[63:48] !== 16'h5AFF) begin
            n_err++; $display("FAIL graphic_first2: got %h required 5AFF", cap[63:48]);
        end
        n_vec++;
        if (cap !== exp) begin
            n_err++; $display("FAIL graphic_frame: got %h required %h", cap, exp);
        end
        s0_mode = 0; s0_data = {$urandom, 4'h8, 28'($urandom)};
        s0_point = 8'($urandom) | 8'h80; s0_le = 8'hFF; s0_blink = '0;
        exp = exp0();
        run_frame(0, 1, 0, 0, cap, e, l, lat, t, mn, mx);
        n_vec++;
        if (cap[63:56] !== 8'h00) begin
            n_err++; $display("FAIL point_digit8: got %h required 00", cap[63:56]);
        end
        n_vec++;
        if (cap !== exp) begin
            n_err++; $display("FAIL point_frame: got %h required %h", cap, exp);
        end
    endtask

    task automatic test_start_busy();
        logic [63:0] cap, exp;
        int e, l, lat, mn, mx;
        bit seen;
        longint t;
        s0_mode = 0; s0_data = {$urandom, $urandom};
        s0_point = 8'($urandom); s0_le = 8'($urandom); s0_blink = '0;
        exp = exp0();
        run_frame(0, 1, 10, 100, cap, e, l, lat, t, mn, mx);
        n_vec++;
        if (cap !== exp) begin
            n_err++; $display("FAIL busy_capture: got %h required %h", cap, exp);
        end
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s0_busy || s0_done) seen = 1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL busy_not_queued: extra frame seen=%b required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [63:0] cap, exp;
        int e, l, lat, mn, mx;
        longint t;
        for (int k = 0; k < 6; k++) begin
            s0_mode = 1'($urandom); s0_data = {$urandom, $urandom};
            s0_point = 8'($urandom); s0_le = 8'($urandom); s0_blink = 8'($urandom);
            exp = exp0();
            run_frame(0, 1, 0, 0, cap, e, l, lat, t, mn, mx);
            n_vec++;
            if (cap !== exp) begin
                n_err++; $display("FAIL random0_frame[%0d]: got %h required %h", k, cap, exp);
            end
        end
        for (int k = 0; k < 6; k++) begin
            s1_mode = 1'($urandom); s1_data = $urandom;
            s1_point = 4'($urandom); s1_le = 4'($urandom); s1_blink = 4'($urandom);
            exp = exp1();
            run_frame(1, 1, 0, 0, cap, e, l, lat, t, mn, mx);
            n_vec++;
            if (cap !== exp) begin
                n_err++; $display("FAIL random1_frame[%0d]: got %h required %h", k, cap, exp);
            end
        end
    endtask

    task automatic test_small();
        logic [63:0] cap, exp;
        int e, l, lat, mn, mx;
        longint t;
        s1_mode = 0; s1_data = $urandom;
        s1_point = 4'($urandom); s1_le = 4'hF; s1_blink = '0;
        exp = exp1();
        run_frame(1, 1, 0, 0, cap, e, l, lat, t, mn, mx);
        n_vec++;
        if (cap !== exp) begin
            n_err++; $display("FAIL small_frame: got %h required %h", cap, exp);
        end
        n_vec++;
        if (e !== 8*D1) begin
            n_err++; $display("FAIL small_edges: got %0d required %0d", e, 8*D1);
        end
        n_vec++;
        if (mn !== 2 || mx !== 2) begin
            n_err++; $display("FAIL small_sck_period: min %0d max %0d required 2 2", mn, mx);
        end
        n_vec++;
        if (lat !== LAT1) begin
            n_err++; $display("FAIL small_latency: got %0d required %0d", lat, LAT1);
        end
        n_vec++;
        if (l !== C1) begin
            n_err++; $display("FAIL small_latch_len: got %0d required %0d", l, C1);
        end
    endtask

    task automatic test_blink();
        logic [63:0] cap, exp;
        logic [7:0]  normal, want;
        int e, l, lat, mn, mx;
        longint t, t_prev;
        do_reset();
        s0_mode = 0; s0_data = {$urandom, $urandom};
        s0_point = '0; s0_le = 8'hFF; s0_blink = 8'h80;
        normal = hex_tbl[s0_data[31:28]];
        t_prev = 0;
        s0_auto = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp = exp0();
            want = (k == 2 || k == 3) ? 8'hFF : normal;
            run_frame(0, 0, 0, 0, cap, e, l, lat, t, mn, mx);
            if (k == 4) s0_auto = 1'b0;
            n_vec++;
            if (cap[63:56] !== want) begin
                n_err++; $display("FAIL blink_digit7[%0d]: got %h required %h", k, cap[63:56], want);
            end
            n_vec++;
            if (cap !== exp) begin
                n_err++; $display("FAIL blink_frame[%0d]: got %h required %h", k, cap, exp);
            end
            if (k > 0) begin
                n_vec++;
                if (t - t_prev !== longint'(LAT0 + 1)) begin
                    n_err++; $display("FAIL blink_period[%0d]: got %0d required %0d", k, t - t_prev, LAT0 + 1);
                end
            end
            t_prev = t;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_text();
        test_graphic();
        test_start_busy();
        test_random();
        test_small();
        test_blink();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
